// File: rtl/wbs_ram.sv
// Wishbone B4 classic slave wrapping a 2**AW x 32 byte-writable RAM.
// Requests are terminated with a one-cycle ack (in window) or err (decode error) after WAIT_CYCLES wait states.
module wbs_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          AW          = 10,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_addr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;

    logic        is_idle;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic        dec_err;
    logic        mem_we;
    logic [AW-1:0] req_idx;

    // In IDLE the request is still on the bus; afterwards the latched copy is used.
    assign is_idle  = (state_q == ST_IDLE);
    assign req_addr = is_idle ? wb_addr_i : addr_q;
    assign req_we   = is_idle ? wb_we_i   : we_q;
    assign req_sel  = is_idle ? wb_sel_i  : sel_q;
    assign req_dat  = is_idle ? wb_dat_i  : dat_q;
    assign req_idx  = req_addr[AW+1:2];

    assign dec_err = (req_addr[31:AW+2] != BASE_ADDR[31:AW+2])
                   || (req_addr[1:0] != 2'b00)
                   || (req_sel == 4'b0000);

    // State and request registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d = wb_addr_i;
                    we_d   = wb_we_i;
                    sel_d  = wb_sel_i;
                    dat_d  = wb_dat_i;
                    cnt_d  = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = dec_err ? ST_ERR : ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = dec_err ? ST_ERR : ST_ACK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Writes commit on the edge entering ACK; a reset in progress blocks them.
    assign mem_we = (state_d == ST_ACK) && req_we && rst_n_i;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && req_sel[b]) begin
                mem[req_idx][8*b +: 8] <= req_dat[8*b +: 8];
            end
        end
        rdata_q <= mem[req_idx];
    end

    // Output decode.
    always_comb begin
        wb_ack_o = (state_q == ST_ACK);
        wb_err_o = (state_q == ST_ERR);
        wb_dat_o = ((state_q == ST_ACK) && !we_q) ? rdata_q : 32'd0;
    end

endmodule

// File: tb/tb_wbs_ram.sv
// Bench for wbs_ram: four instances with wait states 0/2/3/4, directed scenarios plus random traffic
// checked against an array model of the RAM window.
module tb_wbs_ram;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        cyc  [4];
    logic        stb  [4];
    logic        we   [4];
    logic [31:0] addr [4];
    logic [3:0]  sel  [4];
    logic [31:0] dati [4];
    logic [31:0] dato [4];
    logic        ack  [4];
    logic        err  [4];

    logic [31:0] model [4][DEPTH];
    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        wbs_ram #(
            .BASE_ADDR  (BASE),
            .AW         (AW),
            .WAIT_CYCLES(gi == 0 ? 0 : gi + 1)
        ) u_dut (
            .clk_i    (clk),
            .rst_n_i  (rst_n),
            .wb_cyc_i (cyc[gi]),
            .wb_stb_i (stb[gi]),
            .wb_we_i  (we[gi]),
            .wb_addr_i(addr[gi]),
            .wb_sel_i (sel[gi]),
            .wb_dat_i (dati[gi]),
            .wb_dat_o (dato[gi]),
            .wb_ack_o (ack[gi]),
            .wb_err_o (err[gi])
        );
    end

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : i + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; caller is 1 time unit after a clock edge with the slave idle.
    task automatic access(input int i, input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd);
        logic        e;
        logic        early;
        int          n;
        int          idx;
        logic [31:0] expd;
        e = (a < BASE) || (a >= BASE + 4 * DEPTH) || (a % 4 != 0) || (s == 4'd0);
        idx  = e ? 0 : int'((a - BASE) / 4);
        expd = model[i][idx];
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; addr[i] = a; sel[i] = s; dati[i] = d;
        n = 0;
        early = 1'b0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[i] || err[i]) break;
            if (dato[i] !== 32'd0) early = 1'b1;
        end
        rd = dato[i];
        $display("inst=%0d we=%0b addr=%h sel=%h wdat=%h -> ack=%0b err=%0b dat=%h lat=%0d",
                 i, w, a, s, d, ack[i], err[i], dato[i], n);
        check("latency", n, wait_of(i) + 1);
        check("ack", ack[i], !e);
        check("err", err[i], e);
        check("rdata", dato[i], (!e && !w) ? expd : 32'd0);
        check("dat_before_ack", early, 1'b0);
        cyc[i] = 1'b0; stb[i] = 1'b0;
        if (!e && w) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[i][idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        @(posedge clk); #1;
        check("idle_after", {ack[i], err[i], dato[i]}, 34'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] old;
        logic [5:0]  pat;
        logic        flag;
        int          n;
        int          r;

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc[i] = 0; stb[i] = 0; we[i] = 0; addr[i] = 0; sel[i] = 0; dati[i] = 0;
        end
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            check("reset_ack", ack[i], 1'b0);
            check("reset_err", err[i], 1'b0);
            check("reset_dat", dato[i], 32'd0);
        end
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill every word so the model is fully known.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                access(i, 1'b1, BASE + 32'(4 * k), 4'hF, $urandom, rd);
            end
        end

        // W=2 full write then read of the same word.
        access(1, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, rd);
        access(1, 1'b0, BASE + 32'h10, 4'h3, 32'd0, rd);
        check("w2_read", rd, 32'hDEADBEEF);

        // W=0 byte-lane merge.
        access(0, 1'b1, BASE + 32'h8, 4'hF, 32'h11223344, rd);
        access(0, 1'b1, BASE + 32'h8, 4'b0010, 32'h0000AA00, rd);
        access(0, 1'b0, BASE + 32'h8, 4'hF, 32'd0, rd);
        check("merge", rd, 32'h1122AA44);

        // Decode errors must not touch the RAM (out-of-range aliases onto word 0).
        old = model[0][0];
        access(0, 1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'h0BADBAD0, rd);
        access(0, 1'b1, BASE + 32'h2, 4'hF, 32'h0BADBAD1, rd);
        access(0, 1'b1, BASE, 4'h0, 32'h0BADBAD2, rd);
        access(0, 1'b0, BASE, 4'hF, 32'd0, rd);
        check("err_word0", rd, old);

        // W=4 abort by dropping cyc in WAIT.
        old = model[3][3];
        a = BASE + 32'hC;
        cyc[3] = 1; stb[3] = 1; we[3] = 1; addr[3] = a; sel[3] = 4'hF; dati[3] = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc[3] = 0; stb[3] = 0;
        flag = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack[3] || err[3]) flag = 1'b1;
        end
        $display("inst=3 abort write addr=%h -> termination_seen=%0b", a, flag);
        check("abort_quiet", flag, 1'b0);
        access(3, 1'b0, a, 4'hF, 32'd0, rd);
        check("abort_word", rd, old);

        // W=3 asynchronous reset in WAIT during a write.
        old = model[2][5];
        a = BASE + 32'h14;
        cyc[2] = 1; stb[2] = 1; we[2] = 1; addr[2] = a; sel[2] = 4'hF; dati[2] = 32'h0BADF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        $display("inst=2 reset in WAIT -> ack=%0b err=%0b dat=%h", ack[2], err[2], dato[2]);
        check("rst_wait_ack", ack[2], 1'b0);
        check("rst_wait_err", err[2], 1'b0);
        check("rst_wait_dat", dato[2], 32'd0);
        cyc[2] = 0; stb[2] = 0;
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        access(2, 1'b0, a, 4'hF, 32'd0, rd);
        check("rst_word", rd, old);
        access(2, 1'b1, a, 4'hF, 32'h600DF00D, rd);
        access(2, 1'b0, a, 4'hF, 32'd0, rd);
        check("rst_new_write", rd, 32'h600DF00D);

        // Reset asserted during a read ACK clears the outputs before the next edge.
        cyc[1] = 1; stb[1] = 1; we[1] = 0; addr[1] = BASE + 32'h10; sel[1] = 4'hF; dati[1] = 0;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[1] || err[1]) break;
        end
        check("rst_ack_pre", {ack[1], dato[1]}, {1'b1, model[1][4]});
        #2 rst_n = 1'b0;
        #1;
        $display("inst=1 reset in ACK -> ack=%0b dat=%h", ack[1], dato[1]);
        check("rst_ack_ack", ack[1], 1'b0);
        check("rst_ack_dat", dato[1], 32'd0);
        cyc[1] = 0; stb[1] = 0;
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Strobe held high: one ack per request, each separated by an idle cycle.
        old = model[0][4];
        cyc[0] = 1; stb[0] = 1; we[0] = 0; addr[0] = BASE + 32'h10; sel[0] = 4'hF;
        pat = 6'd0;
        flag = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            pat = {pat[4:0], ack[0]};
            if (ack[0] && dato[0] !== old) flag = 1'b0;
            if (err[0]) flag = 1'b0;
        end
        cyc[0] = 0; stb[0] = 0;
        $display("inst=0 held strobe -> ack pattern=%b", pat);
        check("hold_pattern", pat, 6'b101010);
        check("hold_data", flag, 1'b1);
        @(posedge clk); #1;

        // Random traffic including decode errors.
        for (int i = 0; i < 4; i++) begin
            repeat (30) begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, DEPTH - 1));
                else if (r == 1) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                else if (r == 2) a = BASE - 32'd4;
                else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                access(i, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wbs_ram.md
WBS_RAM -- requirements
Module: wbs_ram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base address of the RAM window; must be aligned to 4*2**AW.
REQ-002 SHALL have parameter AW, default 10: word-address width; depth = 2**AW 32-bit words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, legal range 0..15: wait states inserted before ack/err.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port wb_cyc_i, input, 1 bit: bus cycle valid, driven by the master.
REQ-007 SHALL have port wb_stb_i, input, 1 bit: strobe; held by the master until ack or err.
REQ-008 SHALL have port wb_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port wb_addr_i, input, 32 bits: byte address.
REQ-010 SHALL have port wb_sel_i, input, 4 bits: byte enables; bit k selects dat[8k+7:8k].
REQ-011 SHALL have port wb_dat_i, input, 32 bits: write data.
REQ-012 SHALL have port wb_dat_o, output, 32 bits: read data.
REQ-013 SHALL have port wb_ack_o, output, 1 bit: normal termination, registered.
REQ-014 SHALL have port wb_err_o, output, 1 bit: error termination, registered.

Function
REQ-015 SHALL implement the Wishbone B4 classic (non-pipelined) slave protocol with a 4-state FSM: IDLE, WAIT, ACK, ERR.
REQ-016 In IDLE, at an edge where wb_cyc_i=1 and wb_stb_i=1, the block SHALL latch addr, we, sel and dat, and load the wait counter with WAIT_CYCLES.
REQ-017 Decode error SHALL be any of these conditions:
- addr[31:AW+2] != BASE_ADDR[31:AW+2];
- addr[1:0] != 0;
- sel == 4'b0000.
REQ-018 On a decode error, the FSM SHALL go to ERR after the same wait as a good access; no memory access SHALL occur.
REQ-019 When WAIT_CYCLES=0, the FSM SHALL go from IDLE directly to ACK or ERR; ack_o/err_o SHALL be high in the cycle immediately after the sampling edge.
REQ-020 When WAIT_CYCLES=W>0, the FSM SHALL go to WAIT and decrement the counter each edge; on the edge where the counter equals 1 it SHALL go to ACK/ERR. ack_o/err_o SHALL therefore rise W+1 cycles after the sampling edge.
REQ-021 ACK and ERR SHALL each last exactly one cycle; the outputs SHALL be high only in that state; wb_stb_i SHALL be ignored there; the next state SHALL be IDLE.
REQ-022 Back-to-back accesses SHALL have a minimum spacing of one IDLE cycle; the next request SHALL be sampled no earlier than the edge after ACK/ERR.
REQ-023 A write SHALL commit on the edge entering ACK, updating only the bytes with sel=1; other bytes SHALL be unchanged.
REQ-024 A read SHALL drive wb_dat_o with the full addressed word, independent of sel, during the ACK cycle.
REQ-025 wb_dat_o SHALL be 0 in all other cycles, including ERR and write ACK.
REQ-026 ack_o and err_o SHALL never be high simultaneously.
REQ-027 Abort: if wb_cyc_i=0 at any edge while in WAIT, the FSM SHALL return to IDLE with no ack, no err and no memory write.
REQ-028 Memory SHALL be a 2**AW x 32 array indexed by addr[AW+1:2].
REQ-029 Memory contents SHALL NOT be reset.

Reset
REQ-030 While rst_n_i=0, asynchronously and independent of the clock, the block SHALL drive: state=IDLE, wait counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, latched request registers=0.
REQ-031 Reset asserted mid-access (WAIT or ACK) SHALL cancel the access; a write not yet committed SHALL NOT occur.
REQ-032 The first request SHALL be sampled no earlier than the first rising edge after rst_n_i deasserts.

Verification
REQ-033 Scenario (W=2): write 32'hDEADBEEF to BASE+0x10 with sel=4'hF -> ack_o high for exactly 1 cycle, 3 cycles after the sampling edge. Then read BASE+0x10 -> dat_o=32'hDEADBEEF with ack, and dat_o=0 the following cycle.
REQ-034 Scenario (W=0): write 32'h11223344, then write 32'h0000AA00 with sel=4'b0010 to the same address, then read -> 32'h1122AA44, with ack 1 cycle after each request.
REQ-035 Scenario: write to BASE + 4*2**AW (out of range), to address 0x...02 (misaligned), and with sel=0 -> err_o pulses 1 cycle for each, ack_o stays 0, and a read of word 0 is unchanged.
REQ-036 Scenario (W=4): write 32'hCAFEF00D, drop wb_cyc_i 2 cycles after sampling -> no ack/err ever, FSM back in IDLE, and a read of the address returns the prior value.
REQ-037 Scenario (W=3): assert rst_n_i=0 asynchronously in WAIT during a write -> ack_o, err_o and dat_o go to 0 before the next clock edge; after release, a read returns the prior value and a new request completes normally.
REQ-038 Scenario: hold wb_stb_i=1 through the ACK cycle -> exactly one ack, and the next request is sampled only from the IDLE cycle after ACK.
